// File: rtl/leaf_controller.sv
// Per-FPGA decode controller: walks the PE array through load/boundary/grow-merge-peel and reports one result.
// Latency: accepted message changes global_stage next cycle; result appears one cycle after PEELING.
// Backpressure: ready_from_parent only in IDLE; result held in RESULT_VALID until ready_to_parent.
module leaf_controller #(
    parameter logic [7:0] FPGA_ID                 = 8'h01,
    parameter int         CTRL_FIFO_WIDTH         = 64,
    parameter int         ITERATION_COUNTER_WIDTH = 8,
    parameter int         MAXIMUM_DELAY           = 2,
    parameter int         STAGE_WIDTH             = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CTRL_FIFO_WIDTH-1:0] data_from_parent,
    input  logic                       valid_from_parent,
    output logic                       ready_from_parent,
    output logic [CTRL_FIFO_WIDTH-1:0] data_to_parent,
    output logic                       valid_to_parent,
    input  logic                       ready_to_parent,
    output logic [STAGE_WIDTH-1:0]     global_stage,
    output logic [47:0]                boundary_config,
    input  logic                       router_busy,
    input  logic                       odd_clusters
);

    // Stage codes double as the FSM state encoding.
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_SET_BOUNDARIES      = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(4);
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = STAGE_WIDTH'(5);
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = STAGE_WIDTH'(6);

    localparam logic [7:0] HEADER_INITIALIZE_DECODING = 8'h00;
    localparam logic [7:0] HEADER_SET_BOUNDARIES      = 8'h01;
    localparam logic [7:0] HEADER_DECODE_BLOCK        = 8'h02;
    localparam logic [7:0] HEADER_RESULT              = 8'h03;

    localparam int MSG_DEST_MSB   = 63;
    localparam int MSG_DEST_LSB   = 56;
    localparam int MSG_HEADER_MSB = 55;
    localparam int MSG_HEADER_LSB = 48;

    localparam int IW = ITERATION_COUNTER_WIDTH;
    localparam int DW = (MAXIMUM_DELAY < 1) ? 1 : $clog2(MAXIMUM_DELAY + 1);
    localparam logic [IW-1:0] ITER_MAX  = '1;
    localparam logic [DW-1:0] DELAY_MAX = DW'(MAXIMUM_DELAY);

    logic [STAGE_WIDTH-1:0]     r_stage;
    logic [STAGE_WIDTH-1:0]     w_next_stage;
    logic [IW-1:0]              r_iter;
    logic [15:0]                r_cycle;
    logic [DW-1:0]              r_delay;
    logic                       r_overflow;
    logic                       r_busy_q;
    logic                       r_valid;
    logic [CTRL_FIFO_WIDTH-1:0] r_data;
    logic [47:0]                r_boundary;

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_for_me;
    logic [7:0]                 w_dest;
    logic [7:0]                 w_hdr;
    logic                       w_merge_done;
    logic [15:0]                w_cycle_next;
    logic [7:0]                 w_iter_field;
    logic [63:0]                w_result;

    assign w_dest       = data_from_parent[MSG_DEST_MSB:MSG_DEST_LSB];
    assign w_hdr        = data_from_parent[MSG_HEADER_MSB:MSG_HEADER_LSB];
    assign w_for_me     = (w_dest == FPGA_ID) || (w_dest == 8'hff);
    assign w_accept     = valid_from_parent && w_ready;
    assign w_cycle_next = (r_cycle == 16'hffff) ? r_cycle : r_cycle + 16'd1;
    assign w_iter_field = 8'(r_iter);
    // The result is captured in PEELING, so it already includes PEELING's own cycle.
    assign w_result     = {8'h00, HEADER_RESULT, FPGA_ID, w_iter_field,
                           15'd0, r_overflow, w_cycle_next};

    // State register; the state itself is the broadcast stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_stage <= STAGE_IDLE;
        else       r_stage <= w_next_stage;
    end

    // Next-stage decode; merge completes after MAXIMUM_DELAY quiet cycles were already counted.
    always_comb begin
        w_next_stage = r_stage;
        w_merge_done = 1'b0;
        case (r_stage)
            STAGE_IDLE: begin
                if (w_accept && w_for_me) begin
                    case (w_hdr)
                        HEADER_INITIALIZE_DECODING: w_next_stage = STAGE_MEASUREMENT_LOADING;
                        HEADER_SET_BOUNDARIES:      w_next_stage = STAGE_SET_BOUNDARIES;
                        HEADER_DECODE_BLOCK:        w_next_stage = STAGE_GROW;
                        default:                    w_next_stage = STAGE_IDLE;
                    endcase
                end
            end
            STAGE_MEASUREMENT_LOADING: w_next_stage = STAGE_IDLE;
            STAGE_SET_BOUNDARIES:      w_next_stage = STAGE_IDLE;
            STAGE_GROW:                w_next_stage = STAGE_MERGE;
            STAGE_MERGE: begin
                if (!r_busy_q && (r_delay == DELAY_MAX)) begin
                    w_merge_done = 1'b1;
                    if (odd_clusters && (r_iter != ITER_MAX)) w_next_stage = STAGE_GROW;
                    else                                      w_next_stage = STAGE_PEELING;
                end
            end
            STAGE_PEELING:      w_next_stage = STAGE_RESULT_VALID;
            STAGE_RESULT_VALID: if (ready_to_parent) w_next_stage = STAGE_IDLE;
            default:            w_next_stage = STAGE_IDLE;
        endcase
    end

    // Output decode: only the parent-side ready is combinational.
    always_comb begin
        w_ready = (r_stage == STAGE_IDLE);
    end

    // Counters, busy sampling, boundary latch and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iter     <= '0;
            r_cycle    <= '0;
            r_delay    <= '0;
            r_overflow <= 1'b0;
            r_busy_q   <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_boundary <= '0;
        end else begin
            r_busy_q <= router_busy;
            r_valid  <= (w_next_stage == STAGE_RESULT_VALID);
            if (w_accept && w_for_me && (w_hdr == HEADER_SET_BOUNDARIES))
                r_boundary <= data_from_parent[47:0];
            if (w_accept && w_for_me && (w_hdr == HEADER_DECODE_BLOCK)) begin
                r_iter     <= '0;
                r_cycle    <= '0;
                r_delay    <= '0;
                r_overflow <= 1'b0;
            end
            case (r_stage)
                STAGE_GROW: begin
                    if (r_iter != ITER_MAX) r_iter <= r_iter + IW'(1);
                    r_delay <= '0;
                    r_cycle <= w_cycle_next;
                end
                STAGE_MERGE: begin
                    r_cycle <= w_cycle_next;
                    if (r_busy_q)               r_delay <= '0;
                    else if (r_delay < DELAY_MAX) r_delay <= r_delay + DW'(1);
                    if (w_merge_done && odd_clusters && (r_iter == ITER_MAX))
                        r_overflow <= 1'b1;
                end
                STAGE_PEELING: begin
                    r_cycle <= w_cycle_next;
                    r_data  <= CTRL_FIFO_WIDTH'(w_result);
                end
                default: ;
            endcase
        end
    end

    assign ready_from_parent = w_ready;
    assign data_to_parent    = r_data;
    assign valid_to_parent   = r_valid;
    assign global_stage      = r_stage;
    assign boundary_config   = r_boundary;

endmodule
